// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: default bus widths used by the
// ALU top and by the result collector, and the unit tag encoding carried with
// every queued result.
package alu_pkg;

    localparam int ARITH_OUT_WIDTH = 32;
    localparam int LOGIC_OUT_WIDTH = 16;
    localparam int CMP_OUT_WIDTH   = 3;
    localparam int SHIFT_OUT_WIDTH = 16;
    localparam int RES_WIDTH       = 32;
    localparam int FIFO_DEPTH      = 4;
    localparam int COUNT_WIDTH     = $clog2(FIFO_DEPTH) + 1;
    localparam int TAG_WIDTH       = 2;

    localparam logic [TAG_WIDTH-1:0] TAG_ARITH = 2'b00;
    localparam logic [TAG_WIDTH-1:0] TAG_LOGIC = 2'b01;
    localparam logic [TAG_WIDTH-1:0] TAG_CMP   = 2'b10;
    localparam logic [TAG_WIDTH-1:0] TAG_SHIFT = 2'b11;

endpackage

// File: rtl/alu_result_collector_if.sv
// Result drain port of the collector: head entry data/tag/carry, valid/ready
// handshake and current queue occupancy.
//   master : driven by the collector (RES_OUT, RES_TAG, RES_CARRY, RES_VALID, COUNT out; RES_READY in)
//   slave  : the consumer side (mirror of master)
interface alu_result_collector_if
    import alu_pkg::*;
#(
    parameter int RES_width   = RES_WIDTH,
    parameter int COUNT_width = COUNT_WIDTH
);
    logic [RES_width-1:0]   RES_OUT;
    logic [TAG_WIDTH-1:0]   RES_TAG;
    logic                   RES_CARRY;
    logic                   RES_VALID;
    logic                   RES_READY;
    logic [COUNT_width-1:0] COUNT;

    modport master (
        output RES_OUT, RES_TAG, RES_CARRY, RES_VALID, COUNT,
        input  RES_READY
    );

    modport slave (
        input  RES_OUT, RES_TAG, RES_CARRY, RES_VALID, COUNT,
        output RES_READY
    );
endinterface

// File: rtl/alu_res_fifo.sv
// Generic synchronous show-ahead FIFO. The head entry is always presented on
// dout straight from storage; pop consumes it on the rising edge.
//   clk, rst_n : clock, asynchronous active-low reset (clears storage too)
//   push, din  : write request and data; accepted when not full, or when full
//                and a pop happens on the same edge
//   pop        : read request; ignored while empty
//   dout       : head entry
//   full, empty, count : occupancy status
module alu_res_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

    // A push into a full queue is allowed only when the head leaves on the
    // same edge; then wr_ptr == rd_ptr and the write replaces the popped slot.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/alu_result_collector.sv
// Collects ALU unit results: decodes the one-hot unit flags, forms a tagged
// 32-bit entry for the single active unit and queues it in a show-ahead FIFO
// drained over a valid/ready port. Multiple simultaneous flags and results
// dropped on a full queue raise sticky error flags.
//   CLK, RST                 : clock, asynchronous active-low reset
//   ARITH_OUT, Carry_out     : arithmetic result and carry
//   LOGIC_OUT, CMP_OUT, SHIFT_OUT : other unit results
//   ARITH/LOGIC/CMP/SHIFT_Flag    : unit-active flags
//   ERR_CLR                  : synchronous clear of the sticky errors
//   res (master)             : drain port (head entry, handshake, COUNT)
//   ERR_MULTI, ERR_OVF       : sticky error flags
module alu_result_collector
    import alu_pkg::*;
#(
    parameter int ARITH_OUT_width = ARITH_OUT_WIDTH,
    parameter int LOGIC_OUT_width = LOGIC_OUT_WIDTH,
    parameter int CMP_OUT_width   = CMP_OUT_WIDTH,
    parameter int SHIFT_OUT_width = SHIFT_OUT_WIDTH,
    parameter int RES_width       = RES_WIDTH,
    parameter int FIFO_DEPTH      = alu_pkg::FIFO_DEPTH
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic [ARITH_OUT_width-1:0] ARITH_OUT,
    input  logic                       Carry_out,
    input  logic [LOGIC_OUT_width-1:0] LOGIC_OUT,
    input  logic [CMP_OUT_width-1:0]   CMP_OUT,
    input  logic [SHIFT_OUT_width-1:0] SHIFT_OUT,
    input  logic                       ARITH_Flag,
    input  logic                       LOGIC_Flag,
    input  logic                       CMP_Flag,
    input  logic                       SHIFT_Flag,
    input  logic                       ERR_CLR,
    alu_result_collector_if.master     res,
    output logic                       ERR_MULTI,
    output logic                       ERR_OVF
);
    localparam int ENTRY_W = TAG_WIDTH + 1 + RES_width;

    logic [3:0]           flags;
    logic                 multi;
    logic                 single;
    logic [RES_width-1:0] entry_data;
    logic [TAG_WIDTH-1:0] entry_tag;
    logic                 entry_carry;
    logic [ENTRY_W-1:0]   head;
    logic                 full;
    logic                 empty;
    logic                 ovf_evt;

    assign flags = {SHIFT_Flag, CMP_Flag, LOGIC_Flag, ARITH_Flag};

    // Clearing the lowest set bit leaves something only if two or more are set.
    assign multi  = |(flags & (flags - 4'd1));
    assign single = (flags != 4'd0) && !multi;

    // Selection is only consumed when exactly one flag is high, so the
    // if-chain order carries no priority meaning.
    always_comb begin
        entry_data  = '0;
        entry_tag   = TAG_ARITH;
        entry_carry = 1'b0;
        if (ARITH_Flag) begin
            entry_data  = RES_width'(ARITH_OUT);
            entry_tag   = TAG_ARITH;
            entry_carry = Carry_out;
        end else if (LOGIC_Flag) begin
            entry_data = RES_width'(LOGIC_OUT);
            entry_tag  = TAG_LOGIC;
        end else if (CMP_Flag) begin
            entry_data = RES_width'(CMP_OUT);
            entry_tag  = TAG_CMP;
        end else if (SHIFT_Flag) begin
            entry_data = RES_width'(SHIFT_OUT);
            entry_tag  = TAG_SHIFT;
        end
    end

    alu_res_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK),
        .rst_n (RST),
        .push  (single),
        .din   ({entry_tag, entry_carry, entry_data}),
        .pop   (res.RES_READY),
        .dout  (head),
        .full  (full),
        .empty (empty),
        .count (res.COUNT)
    );

    assign res.RES_VALID = !empty;
    assign res.RES_TAG   = head[ENTRY_W-1 -: TAG_WIDTH];
    assign res.RES_CARRY = head[RES_width];
    assign res.RES_OUT   = head[RES_width-1:0];

    // Full implies non-empty, so RES_READY alone tells whether a slot frees up.
    assign ovf_evt = single && full && !res.RES_READY;

    // A new error on the same edge as ERR_CLR keeps the flag set.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            ERR_MULTI <= 1'b0;
            ERR_OVF   <= 1'b0;
        end else begin
            ERR_MULTI <= multi   || (ERR_MULTI && !ERR_CLR);
            ERR_OVF   <= ovf_evt || (ERR_OVF   && !ERR_CLR);
        end
    end
endmodule

// File: tb/tb_alu_result_collector.sv
// Randomised self-checking bench for alu_result_collector with a queue-based
// reference model and a few hand-computed directed checks.
module tb_alu_result_collector;
    import alu_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic [31:0] a_out = '0;
    logic        a_carry = 1'b0;
    logic [15:0] l_out = '0;
    logic [2:0]  c_out = '0;
    logic [15:0] s_out = '0;
    logic        fa = 0, fl = 0, fc = 0, fs = 0;
    logic        err_clr = 1'b0;
    logic        err_multi, err_ovf;

    alu_result_collector_if rif ();

    alu_result_collector dut (
        .CLK        (CLK),
        .RST        (RST),
        .ARITH_OUT  (a_out),
        .Carry_out  (a_carry),
        .LOGIC_OUT  (l_out),
        .CMP_OUT    (c_out),
        .SHIFT_OUT  (s_out),
        .ARITH_Flag (fa),
        .LOGIC_Flag (fl),
        .CMP_Flag   (fc),
        .SHIFT_Flag (fs),
        .ERR_CLR    (err_clr),
        .res        (rif),
        .ERR_MULTI  (err_multi),
        .ERR_OVF    (err_ovf)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] d;
        logic [1:0]  t;
        logic        c;
    } ent_t;

    ent_t m_q[$];
    bit   m_multi = 0;
    bit   m_ovf   = 0;
    bit   chk_en  = 0;
    int   total   = 0;
    int   bad     = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: what the queue must hold after one rising edge.
    task automatic model_step();
        int   n;
        bit   ovf_now;
        ent_t e;
        n = int'(fa) + int'(fl) + int'(fc) + int'(fs);
        ovf_now = 0;
        if (rif.RES_READY && m_q.size() > 0) void'(m_q.pop_front());
        if (n == 1) begin
            if (fa)      begin e.d = a_out;         e.t = 2'd0; e.c = a_carry; end
            else if (fl) begin e.d = {16'h0, l_out}; e.t = 2'd1; e.c = 1'b0;   end
            else if (fc) begin e.d = {29'h0, c_out}; e.t = 2'd2; e.c = 1'b0;   end
            else         begin e.d = {16'h0, s_out}; e.t = 2'd3; e.c = 1'b0;   end
            if (m_q.size() < 4) m_q.push_back(e);
            else ovf_now = 1;
        end
        m_multi = (n > 1) || (m_multi && !err_clr);
        m_ovf   = ovf_now || (m_ovf && !err_clr);
    endtask

    always @(negedge CLK) begin
        if (chk_en) begin
            chk("valid", 64'(rif.RES_VALID), 64'(m_q.size() > 0));
            chk("count", 64'(rif.COUNT), 64'(m_q.size()));
            chk("err_multi", 64'(err_multi), 64'(m_multi));
            chk("err_ovf", 64'(err_ovf), 64'(m_ovf));
            if (m_q.size() > 0) begin
                chk("res_out", 64'(rif.RES_OUT), 64'(m_q[0].d));
                chk("res_tag", 64'(rif.RES_TAG), 64'(m_q[0].t));
                chk("res_carry", 64'(rif.RES_CARRY), 64'(m_q[0].c));
            end
        end
    end

    // Called just after a falling edge; returns just after the next one.
    task automatic cycle(input logic [3:0] f, input logic rdy, input logic clr);
        {fs, fc, fl, fa} = f;
        rif.RES_READY = rdy;
        err_clr = clr;
        @(posedge CLK);
        model_step();
        @(negedge CLK);
    endtask

    task automatic rand_data();
        a_out   = $urandom;
        a_carry = 1'($urandom_range(0, 1));
        l_out   = 16'($urandom);
        c_out   = 3'($urandom);
        s_out   = 16'($urandom);
    endtask

    initial begin
        logic [3:0] f;
        int r;
        rif.RES_READY = 1'b0;
        #12;
        chk("rst_valid", 64'(rif.RES_VALID), 64'd0);
        chk("rst_count", 64'(rif.COUNT), 64'd0);
        chk("rst_errs", 64'({err_multi, err_ovf}), 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        chk_en = 1;

        // First arith result appears one edge later.
        a_out = 32'h1C; a_carry = 1'b0;
        cycle(4'b0001, 1'b0, 1'b0);
        chk("t1_valid", 64'(rif.RES_VALID), 64'd1);
        chk("t1_out", 64'(rif.RES_OUT), 64'h1C);
        chk("t1_tag", 64'(rif.RES_TAG), 64'd0);
        chk("t1_count", 64'(rif.COUNT), 64'd1);
        cycle(4'b0000, 1'b1, 1'b0);

        // Fill with logic results, fifth one overflows.
        l_out = 16'h0018;
        for (int i = 0; i < 5; i++) cycle(4'b0010, 1'b0, 1'b0);
        chk("t2_count", 64'(rif.COUNT), 64'd4);
        chk("t2_ovf", 64'(err_ovf), 64'd1);
        chk("t2_out", 64'(rif.RES_OUT), 64'h18);
        chk("t2_tag", 64'(rif.RES_TAG), 64'd1);

        // Push and pop on a full queue.
        c_out = 3'b010;
        cycle(4'b0100, 1'b1, 1'b0);
        chk("t3_count", 64'(rif.COUNT), 64'd4);
        chk("t3_ovf", 64'(err_ovf), 64'd1);
        for (int i = 0; i < 3; i++) cycle(4'b0000, 1'b1, 1'b0);
        chk("t3_tail_out", 64'(rif.RES_OUT), 64'h2);
        chk("t3_tail_tag", 64'(rif.RES_TAG), 64'd2);
        cycle(4'b0000, 1'b1, 1'b0);

        // Two flags at once.
        cycle(4'b1001, 1'b0, 1'b0);
        chk("t4_count", 64'(rif.COUNT), 64'd0);
        chk("t4_multi", 64'(err_multi), 64'd1);
        cycle(4'b0000, 1'b0, 1'b1);
        chk("t4_clr", 64'(err_multi), 64'd0);

        // Streaming with continuous drain: pointer wrap.
        for (int i = 0; i < 6; i++) begin
            rand_data();
            cycle(4'b0001 << (i % 4), 1'b1, 1'b0);
        end
        cycle(4'b0000, 1'b1, 1'b0);

        // Asynchronous reset with three queued entries.
        for (int i = 0; i < 3; i++) begin
            rand_data();
            cycle(4'b0010, 1'b0, 1'b0);
        end
        chk("t6_pre_count", 64'(rif.COUNT), 64'd3);
        #2;
        chk_en = 0;
        RST = 1'b0;
        #1;
        chk("t6_valid", 64'(rif.RES_VALID), 64'd0);
        chk("t6_count", 64'(rif.COUNT), 64'd0);
        m_q.delete();
        m_multi = 0;
        m_ovf = 0;
        @(negedge CLK);
        RST = 1'b1;
        chk_en = 1;

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rand_data();
            r = int'($urandom_range(0, 9));
            if (r < 2)      f = 4'b0000;
            else if (r < 9) f = 4'b0001 << $urandom_range(0, 3);
            else begin
                f = 4'b0001 << $urandom_range(0, 3);
                f = f | (4'b0001 << $urandom_range(0, 3));
                if (f == 4'b0001 || f == 4'b0010 || f == 4'b0100 || f == 4'b1000)
                    f = 4'b0110;
            end
            cycle(f, 1'($urandom_range(0, 9) < 5), 1'($urandom_range(0, 19) == 0));
        end

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
